// File: rtl/wps_src_mux.sv
// wps_src_mux: N-source read-data selector with priority start arbiter, drain window and stray-data flag
// Optional feature macro: WPS_SRC_MUX_STATS_EN adds per-source forwarded-beat counters on beat_cnt_out
module wps_src_mux #(
   parameter int N_SRC     = 2,
   parameter int DATA_W    = 288,
   parameter int SEL_W     = 1,
   parameter int DRAIN_CYC = 4
) (
   input  logic                    mem_clk,
   input  logic                    mem_rst,
   input  logic [N_SRC-1:0]        src_start_in,
   input  logic                    send_done_in,
   input  logic [N_SRC*DATA_W-1:0] src_read_data_in,
   input  logic [N_SRC-1:0]        src_read_data_valid_in,
   input  logic [N_SRC-1:0]        src_data_ready_in,
   output logic [N_SRC-1:0]        src_read_req_out,
   input  logic                    rx_ready_in,
   output logic [DATA_W-1:0]       tx_data_out,
   output logic                    tx_data_valid_out,
   output logic                    tx_data_ready_out,
   output logic [SEL_W-1:0]        sel_out,
   output logic                    busy_out,
   output logic                    stray_err_out
`ifdef WPS_SRC_MUX_STATS_EN
   ,output logic [N_SRC*32-1:0]    beat_cnt_out
`endif
);
   localparam int CW = $clog2(DRAIN_CYC + 1);
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
   state_t           state;
   logic [SEL_W-1:0] sel, pend, start_idx, foreign_idx, next_pend;
   logic             pend_v, next_pend_v, sel_valid, sel_ready, drain_done, leave_active;
   logic [CW-1:0]    drain_cnt;
   logic [N_SRC-1:0] sel_oh, foreign, stray;
   logic [DATA_W-1:0] sel_data;
   function automatic logic [SEL_W-1:0] lowest(input logic [N_SRC-1:0] v);
      lowest = '0;
      for (int i = N_SRC - 1; i >= 0; i--) if (v[i]) lowest = SEL_W'(i);
   endfunction
   assign sel_out  = sel;
   assign busy_out = state != IDLE;
   // source selection, arbitration and drain-exit decode
   always_comb begin
      sel_oh       = N_SRC'(1) << sel;
      foreign      = src_start_in & ~sel_oh;
      start_idx    = lowest(src_start_in);
      foreign_idx  = lowest(foreign);
      sel_valid    = |(src_read_data_valid_in & sel_oh);
      sel_ready    = |(src_data_ready_in & sel_oh);
      sel_data     = '0;
      for (int i = 0; i < N_SRC; i++) if (SEL_W'(i) == sel) sel_data = src_read_data_in[i*DATA_W +: DATA_W];
      next_pend_v  = pend_v | (|src_start_in);
      next_pend    = (|src_start_in && (!pend_v || start_idx < pend)) ? start_idx : pend;
      drain_done   = !sel_valid && drain_cnt == CW'(DRAIN_CYC - 1);
      leave_active = (|foreign) | send_done_in;
      stray        = src_read_data_valid_in & ((state == IDLE) ? {N_SRC{1'b1}} : ~sel_oh);
   end
   // state machine with registered forwarding path and sticky stray flag
   always_ff @(posedge mem_clk or posedge mem_rst)
      if (mem_rst) begin
         state             <= IDLE;
         sel               <= '0;
         pend              <= '0;
         pend_v            <= 1'b0;
         drain_cnt         <= '0;
         src_read_req_out  <= '0;
         tx_data_out       <= '0;
         tx_data_valid_out <= 1'b0;
         tx_data_ready_out <= 1'b0;
         stray_err_out     <= 1'b0;
      end else begin
         stray_err_out     <= stray_err_out | (|stray);
         src_read_req_out  <= (state == ACTIVE && !leave_active) ? (sel_oh & {N_SRC{rx_ready_in}}) : '0;
         tx_data_out       <= (state == IDLE) ? '0 : sel_data;
         tx_data_valid_out <= state != IDLE && sel_valid;
         tx_data_ready_out <= state != IDLE && sel_ready;
         case (state)
            IDLE:
               if (|src_start_in) begin
                  sel   <= start_idx;
                  state <= ACTIVE;
               end
            ACTIVE:
               if (leave_active) begin
                  pend      <= foreign_idx;
                  pend_v    <= |foreign;
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end
            DRAIN: begin
               pend   <= next_pend;
               pend_v <= next_pend_v;
               if (sel_valid) drain_cnt <= '0;
               else if (drain_done) begin
                  drain_cnt <= '0;
                  pend_v    <= 1'b0;
                  sel       <= next_pend_v ? next_pend : sel;
                  state     <= next_pend_v ? ACTIVE : IDLE;
               end else drain_cnt <= drain_cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
`ifdef WPS_SRC_MUX_STATS_EN
   // count valid beats forwarded from each source
   always_ff @(posedge mem_clk or posedge mem_rst)
      if (mem_rst) beat_cnt_out <= '0;
      else
         for (int i = 0; i < N_SRC; i++)
            if (state != IDLE && sel_valid && SEL_W'(i) == sel) beat_cnt_out[i*32 +: 32] <= beat_cnt_out[i*32 +: 32] + 32'd1;
`endif
endmodule
